fifo_rd_stream_adapter: RTL and testbench
=========================================

FIFO_RD_STREAM_ADAPTER -- requirements
Module: fifo_rd_stream_adapter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of FIFO read data and stream data.
REQ-002 Parameter BURST_LEN, default 4: number of stream beats per burst (legal range 2..16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; 1 = drain FIFO, 0 = stop fetching and flush.
REQ-006 fifo_empty  input  1  upstream sync_fifo_16x16 empty flag.
REQ-007 fifo_data  input  DATA_WIDTH  upstream FIFO data_out; valid the cycle after a read.
REQ-008 fifo_rd_cs  output  1  FIFO read chip select.
REQ-009 fifo_rd_en  output  1  FIFO read enable; always equal to fifo_rd_cs.
REQ-010 m_valid  output  1  stream data valid.
REQ-011 m_ready  input  1  stream sink ready.
REQ-012 m_data  output  DATA_WIDTH  stream data.
REQ-013 m_last  output  1  final beat of a burst.
REQ-014 words_sent  output  16  count of completed stream handshakes, modulo 2^16.

Function
REQ-015 Handshake: a beat transfers when m_valid && m_ready; while m_valid=1 && m_ready=0, m_data and m_last shall hold stable.
REQ-016 FSM states: IDLE, RUN, FLUSH. IDLE->RUN when enable=1. RUN->FLUSH when enable=0. FLUSH->IDLE when buffer empty and no read in flight. FLUSH->RUN when enable=1.
REQ-017 Read issue: assert fifo_rd_cs/en when state=RUN && !fifo_empty && (occ + inflight - pop) < 2. occ = buffer entries; inflight = read issued the previous cycle; pop = handshake this cycle.
REQ-018 Read latency: a read issued in cycle n is captured from fifo_data at the end of cycle n+1 into a 2-entry in-order buffer. The earliest m_valid for that word is cycle n+2.
REQ-019 Throughput: with m_ready held at 1 and the FIFO non-empty, one beat per cycle after the initial 2-cycle latency.
REQ-020 Overrun: the buffer shall never exceed 2 entries. No read shall be issued while fifo_empty=1.
REQ-021 Simultaneous capture and pop in one cycle: the buffer shall shift and load without data loss or reordering.
REQ-022 Beat counter: 0..BURST_LEN-1; increments on each handshake; wraps to 0 after the beat carrying m_last.
REQ-023 In RUN, m_last=1 when m_valid and beat counter = BURST_LEN-1.
REQ-024 In FLUSH, m_last=1 on the final buffered word (occ=1, inflight=0) even if the burst is partial.
REQ-025 Entering IDLE clears the beat counter. If FIFO empties mid-burst in RUN, no m_last is asserted until the burst completes.
REQ-026 words_sent increments by 1 on each handshake and wraps 0xFFFF->0x0000.

Reset
REQ-027 On rst=0, asynchronously: state=IDLE, buffer empty, inflight=0, beat counter=0, words_sent=0.
REQ-028 During reset: fifo_rd_cs=0, fifo_rd_en=0, m_valid=0, m_last=0, m_data=0.
REQ-029 Reset mid-operation discards buffered and in-flight words. After release, the block restarts from IDLE with no spurious m_valid.

Structure
REQ-030 Shared package fifo_pkg holds DATA_WIDTH, ADDR_WIDTH=4, RAM_DEPTH=16, and the FSM state enum.
REQ-031 The 2-entry buffer is one sub-module, skid_buf_2, with its own push/pop/occ interface. The FSM and counters are in the top.

Verification
REQ-032 Bench drives sync_fifo_16x16 upstream of the adapter, with asynchronous active-low rst applied and released before stimulus.
REQ-033 Preload FIFO with 1..16, enable=1, m_ready=1 -> m_data 1..16 on 16 consecutive cycles; m_last on 4, 8, 12, 16; words_sent=16.
REQ-034 Preload 1..16, m_ready=0 for 10 cycles -> exactly 2 reads issued, m_valid=1 with m_data=1 held stable. Release m_ready -> 1..16 in order, no loss.
REQ-035 Preload 3 words, enable=1 -> beats 1, 2, 3 with m_last=0. Write word 4 -> beat 4 with m_last=1.
REQ-036 Preload 1..16, enable=0 after the 6th handshake -> words 7 and 8 drained, m_last on 8, FSM returns to IDLE, fifo_rd_cs stays 0 with 8 words left.
REQ-037 rst pulsed low with 2 buffered words -> m_valid=0 immediately, words_sent=0; after re-enable, stream resumes from next FIFO word.
REQ-038 Force 65537 handshakes -> words_sent=0x0001.

Source files
------------

// File: rtl/fifo_rd_stream_adapter_pkg.sv
// fifo_pkg: shared FIFO geometry and adapter FSM state encoding
package fifo_pkg;
   localparam int DATA_WIDTH = 16;
   localparam int ADDR_WIDTH = 4;
   localparam int RAM_DEPTH  = 16;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;
endpackage

// File: rtl/fifo_rd_stream_adapter_skid_buf_2.sv
// skid_buf_2: two-entry in-order buffer with simultaneous push/pop
module skid_buf_2
   import fifo_pkg::*;
#(
   parameter int W = DATA_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic [1:0]   occ_o,
   output logic [W-1:0] head_o
);
   logic [W-1:0] d0_q, d0_d, d1_q, d1_d;
   logic [1:0]   occ_q, occ_d, base;
   // pop shifts entry 1 forward first; the push then lands in the first free slot
   always_comb begin
      base  = occ_q - {1'b0, pop_i};
      occ_d = base + {1'b0, push_i};
      d0_d  = (push_i && base == 2'd0) ? push_data_i : (pop_i ? d1_q : d0_q);
      d1_d  = (push_i && base != 2'd0) ? push_data_i : d1_q;
   end
   // storage and occupancy registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d0_q  <= '0;
         d1_q  <= '0;
         occ_q <= 2'd0;
      end else begin
         d0_q  <= d0_d;
         d1_q  <= d1_d;
         occ_q <= occ_d;
      end
   end
   assign occ_o  = occ_q;
   assign head_o = d0_q;
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: drains a 1-cycle-latency FIFO into a bursty valid/ready stream
module fifo_rd_stream_adapter
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_cs,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [15:0]           words_sent
);
   localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);
   state_e                state_q, state_d;
   logic                  inflight_q;
   logic [3:0]            beat_q, beat_d;
   logic [15:0]           words_q, words_d;
   logic [1:0]            occ;
   logic [DATA_WIDTH-1:0] head;
   logic                  pop, rd, flush_end;
   skid_buf_2 #(.W(DATA_WIDTH)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .push_i     (inflight_q),
      .push_data_i(fifo_data),
      .pop_i      (pop),
      .occ_o      (occ),
      .head_o     (head)
   );
   assign m_valid    = occ != 2'd0;
   assign m_data     = head;
   assign pop        = m_valid && m_ready;
   assign rd         = state_q == ST_RUN && !fifo_empty &&
                       ({1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2;
   assign fifo_rd_cs = rd;
   assign fifo_rd_en = rd;
   assign flush_end  = state_q == ST_FLUSH && occ == 2'd1 && !inflight_q;
   assign m_last     = m_valid && (beat_q == LAST_BEAT || flush_end);
   assign words_sent = words_q;
   // next state, beat position and handshake count
   always_comb begin
      state_d = state_q == ST_IDLE ? (enable ? ST_RUN : ST_IDLE) :
                state_q == ST_RUN  ? (enable ? ST_RUN : ST_FLUSH) :
                enable ? ST_RUN : ((occ == 2'd0 && !inflight_q) ? ST_IDLE : ST_FLUSH);
      beat_d  = state_q == ST_IDLE ? 4'd0 : (!pop ? beat_q : (m_last ? 4'd0 : beat_q + 4'd1));
      words_d = words_q + 16'(pop);
   end
   // control registers; a read issued now is captured by the buffer next cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         inflight_q <= 1'b0;
         beat_q     <= 4'd0;
         words_q    <= 16'd0;
      end else begin
         state_q    <= state_d;
         inflight_q <= rd;
         beat_q     <= beat_d;
         words_q    <= words_d;
      end
   end
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: directed vector bench with an upstream 16x16 FIFO model
module tb_fifo_rd_stream_adapter;
   import fifo_pkg::*;
   localparam int DW = 16;
   localparam int BL = 4;
   typedef struct {
      logic          en;
      logic          rdy;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
      logic          exp_last;
      logic          exp_rd;
   } vec_t;
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enable = 1'b0;
   logic          m_ready = 1'b0;
   logic          fifo_empty, fifo_rd_cs, fifo_rd_en, m_valid, m_last;
   logic [DW-1:0] fifo_data, m_data;
   logic [15:0]   words_sent;
   int            checks = 0;
   int            failures = 0;
   vec_t          vecs[20];
   always #5 clk = ~clk;
   // upstream sync_fifo_16x16: registered data_out, valid the cycle after a read
   logic          fifo_rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] mem[16];
   logic [3:0]    wp, rp;
   logic [4:0]    cnt;
   logic [DW-1:0] dout;
   logic          rd_fire, wr_fire;
   assign rd_fire    = fifo_rd_cs && fifo_rd_en && cnt != 5'd0;
   assign wr_fire    = wr_en && cnt != 5'd16;
   assign fifo_empty = cnt == 5'd0;
   assign fifo_data  = dout;
   always @(posedge clk or negedge fifo_rst) begin
      if (!fifo_rst) begin
         wp   <= 4'd0;
         rp   <= 4'd0;
         cnt  <= 5'd0;
         dout <= '0;
      end else begin
         if (wr_fire) begin
            mem[wp] <= wr_data;
            wp      <= wp + 4'd1;
         end
         if (rd_fire) begin
            dout <= mem[rp];
            rp   <= rp + 4'd1;
         end
         cnt <= cnt + 5'(wr_fire) - 5'(rd_fire);
      end
   end
   int rd_cnt = 0;
   int bad_rd = 0;
   always @(posedge clk) if (fifo_rd_cs) rd_cnt <= rd_cnt + 1;
   always @(negedge clk) begin
      if ((fifo_rd_cs && fifo_empty) || fifo_rd_cs != fifo_rd_en || dut.u_buf.occ_q > 2'd2)
         bad_rd <= bad_rd + 1;
   end
   fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .fifo_empty(fifo_empty),
      .fifo_data (fifo_data),
      .fifo_rd_cs(fifo_rd_cs),
      .fifo_rd_en(fifo_rd_en),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .words_sent(words_sent)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic preload(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         wr_en   = 1'b1;
         wr_data = DW'(first + i);
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask
   task automatic fifo_clear();
      @(posedge clk); #1;
      fifo_rst = 1'b0;
      #2 fifo_rst = 1'b1;
   endtask
   task automatic idle_out(input int n);
      @(posedge clk); #1;
      enable = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask
   // m_ready already driven; expects n beats first..first+n-1, m_last when (off+i)%BL==BL-1
   task automatic collect(input string tag, input int first, input int n, input int off);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < 200) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            chk($sformatf("%s.data%0d", tag, got), 32'(m_data), 32'(first + got));
            chk($sformatf("%s.last%0d", tag, got), 32'(m_last), 32'((off + got) % BL == BL - 1));
            got++;
         end
         cyc++;
      end
      chk($sformatf("%s.count", tag), got, n);
   endtask
   initial begin
      int base, got, cyc, unstable, hs, order_err;
      logic [DW-1:0] nxt_wr, nxt_exp;
      for (int r = 0; r < 20; r++) begin
         vecs[r].en        = 1'b1;
         vecs[r].rdy       = 1'b1;
         vecs[r].exp_rd    = r >= 1 && r <= 16;
         vecs[r].exp_valid = r >= 3 && r <= 18;
         vecs[r].exp_data  = DW'(r - 2);
         vecs[r].exp_last  = r >= 3 && r <= 18 && (r - 2) % 4 == 0;
      end
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst.rd_cs", 32'(fifo_rd_cs), 0);
      chk("rst.rd_en", 32'(fifo_rd_en), 0);
      chk("rst.valid", 32'(m_valid), 0);
      chk("rst.last", 32'(m_last), 0);
      chk("rst.data", 32'(m_data), 0);
      chk("rst.words", 32'(words_sent), 0);
      @(negedge clk);
      rst = 1'b1;
      fifo_rst = 1'b1;
      // full-rate streaming, vector table
      preload(1, 16);
      foreach (vecs[i]) begin
         @(posedge clk); #1;
         enable  = vecs[i].en;
         m_ready = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("t1[%0d].valid", i), 32'(m_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("t1[%0d].rd", i), 32'(fifo_rd_cs), 32'(vecs[i].exp_rd));
         if (vecs[i].exp_valid) begin
            chk($sformatf("t1[%0d].data", i), 32'(m_data), 32'(vecs[i].exp_data));
            chk($sformatf("t1[%0d].last", i), 32'(m_last), 32'(vecs[i].exp_last));
         end
      end
      chk("t1.words", 32'(words_sent), 16);
      idle_out(4);
      // backpressure: two reads only, head held stable
      preload(1, 16);
      base = rd_cnt;
      unstable = 0;
      @(posedge clk); #1;
      enable  = 1'b1;
      m_ready = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (m_valid && m_data !== 16'd1) unstable++;
      end
      chk("t2.reads", rd_cnt - base, 2);
      chk("t2.valid", 32'(m_valid), 1);
      chk("t2.data", 32'(m_data), 1);
      chk("t2.stable", unstable, 0);
      @(posedge clk); #1;
      m_ready = 1'b1;
      collect("t2", 1, 16, 0);
      idle_out(4);
      // FIFO runs dry mid-burst: no early m_last
      preload(1, 3);
      @(posedge clk); #1;
      enable = 1'b1;
      collect("t3a", 1, 3, 0);
      repeat (5) @(negedge clk);
      chk("t3.gap_valid", 32'(m_valid), 0);
      preload(4, 1);
      collect("t3b", 4, 1, 3);
      idle_out(4);
      // disable after the 6th handshake: drain 7 and 8 then IDLE
      preload(1, 16);
      base = rd_cnt;
      @(posedge clk); #1;
      enable  = 1'b1;
      m_ready = 1'b1;
      got = 0;
      cyc = 0;
      while (got < 8 && cyc < 100) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            chk($sformatf("t4.data%0d", got), 32'(m_data), 32'(got + 1));
            chk($sformatf("t4.last%0d", got), 32'(m_last), 32'(got == 3 || got == 7));
            got++;
            if (got == 6) enable = 1'b0;
         end
         cyc++;
      end
      chk("t4.count", got, 8);
      repeat (6) @(negedge clk);
      chk("t4.state", 32'(dut.state_q), 32'(ST_IDLE));
      chk("t4.reads", rd_cnt - base, 8);
      chk("t4.left", 32'(cnt), 8);
      chk("t4.rd_cs", 32'(fifo_rd_cs), 0);
      chk("t4.valid", 32'(m_valid), 0);
      // reset with two buffered words
      fifo_clear();
      preload(1, 16);
      @(posedge clk); #1;
      enable  = 1'b1;
      m_ready = 1'b0;
      repeat (6) @(negedge clk);
      chk("t5.pre_occ", 32'(dut.u_buf.occ_q), 2);
      #2 rst = 1'b0;
      #1;
      chk("t5.valid", 32'(m_valid), 0);
      chk("t5.words", 32'(words_sent), 0);
      chk("t5.data", 32'(m_data), 0);
      chk("t5.rd_cs", 32'(fifo_rd_cs), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t5.post_valid", 32'(m_valid), 0);
      @(posedge clk); #1;
      m_ready = 1'b1;
      collect("t5", 3, 14, 0);
      // words_sent wrap over 65537 handshakes
      @(posedge clk); #1;
      enable = 1'b0;
      rst    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      chk("t6.words0", 32'(words_sent), 0);
      hs = 0;
      cyc = 0;
      order_err = 0;
      nxt_wr = '0;
      nxt_exp = '0;
      enable = 1'b1;
      m_ready = 1'b1;
      while (hs < 65537 && cyc < 70000) begin
         @(posedge clk); #1;
         if (wr_en) nxt_wr = nxt_wr + 16'd1;
         wr_en   = cnt < 5'd14;
         wr_data = nxt_wr;
         @(negedge clk);
         if (m_valid && m_ready) begin
            if (hs == 65535) chk("t6.words_ffff", 32'(words_sent), 32'h0000_FFFF);
            if (m_data !== nxt_exp) order_err++;
            nxt_exp = nxt_exp + 16'd1;
            hs++;
         end
         cyc++;
      end
      @(posedge clk); #1;
      m_ready = 1'b0;
      wr_en   = 1'b0;
      @(negedge clk);
      chk("t6.count", hs, 65537);
      chk("t6.order", order_err, 0);
      chk("t6.words_wrap", 32'(words_sent), 1);
      chk("no_overrun_or_empty_read", bad_rd, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
